arbitrage_detector: RTL and testbench
=====================================

Name: arbitrage_detector

Overview:
- Sits directly downstream of the UART packet parser and consumes its price_A, price_B and packet_valid outputs.
- Each valid quote pair is evaluated through a 2-stage pipeline. When the absolute spread meets the threshold, the block emits a one-cycle trade pulse carrying direction and spread.
- A cooldown state machine rate-limits trades. Trade and suppressed-opportunity counters are exported for the LED/debug logic.

Parameters:
- PRICE_W, 16, price width in bits; matches parser output.
- MIN_SPREAD, 4, minimum absolute spread (unsigned) that qualifies as an opportunity.
- COOLDOWN, 50000, cycles blocked after a trade (1 ms at 50 MHz); 0 disables cooldown.
- CNT_W, 16, width of trade_count and skip_count.

Ports:
- clk  in  1  system clock, 50 MHz; one clock, no other clock domains.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- price_A  in  PRICE_W  exchange A quote; qualified by packet_valid.
- price_B  in  PRICE_W  exchange B quote; qualified by packet_valid.
- packet_valid  in  1  single-cycle strobe: a new quote pair is present.
- trade_valid  out  1  single-cycle pulse: trade decision issued.
- trade_dir  out  1  0 = buy A / sell B (A cheaper); 1 = buy B / sell A.
- trade_spread  out  PRICE_W  absolute spread of the issued trade.
- busy  out  1  high while in COOLDOWN.
- trade_count  out  CNT_W  number of trades issued; saturating.
- skip_count  out  CNT_W  opportunities suppressed by cooldown; saturating.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, cooldown counter 0, pipeline valid bits 0.
- Stage 1 (edge where packet_valid=1): register A<B flag, |A-B| as PRICE_W unsigned (computed via a PRICE_W+1-bit subtract, so no wrap), and a zero_quote flag (A==0 or B==0). Set s1_valid.
- Stage 2 (next edge): opportunity = s1_valid & !zero_quote & spread>=MIN_SPREAD & spread!=0.
- Equal prices never trade, even when MIN_SPREAD=0.
- Latency: trade_valid is high for exactly one cycle, beginning 2 edges after the packet_valid cycle.
- trade_dir and trade_spread are updated only on a trade and held between trades.
- A new pair is accepted every cycle; back-to-back packet_valid is legal, with no backpressure and no drops.
- FSM states:
  - IDLE: opportunity -> assert trade_valid, trade_count++. If COOLDOWN>0, load cd_cnt=COOLDOWN-1 and go to COOLDOWN; otherwise stay in IDLE.
  - COOLDOWN: busy=1; cd_cnt decrements each cycle. An opportunity here causes no trade and skip_count++. When cd_cnt==0, go to IDLE on that edge.
- Boundaries:
  - A trade in IDLE followed by an opportunity on the very next cycle: the second one is skipped.
  - An opportunity in the same cycle that COOLDOWN exits (cd_cnt==0) is still skipped; the first eligible opportunity arrives one cycle later in IDLE.
  - Counters saturate at all-ones and never wrap.
  - Reset asserted mid-pipeline or mid-cooldown discards in-flight pairs. The first packet after release is evaluated normally.

Optional Feature:
- Macro: ARB_PROFIT_ACCUM_EN.
- Defined: adds output port profit_total (out, 32 bits, reset 0). On every trade, profit_total += trade_spread, zero-extended, saturating at 32'hFFFFFFFF. It updates on the same edge as trade_valid.
- Undefined: no port, no accumulator logic; all other behaviour identical.

Test Plan:
- Bench parameters: MIN_SPREAD=4, COOLDOWN=8.
- Test 1: A=100, B=105, single packet_valid -> trade_valid pulse 2 cycles later, trade_dir=0, trade_spread=5, trade_count=1, busy high for 8 cycles.
- Test 2: A=200, B=197 -> no trade_valid, counters unchanged. Then A=B=300 with MIN_SPREAD=0 build -> no trade.
- Test 3: trade on A=100/B=110, then A=50/B=60 three cycles later -> no pulse, skip_count=1. Packet issued after busy falls -> trade_valid, trade_count=2.
- Test 4: A=0, B=50 and A=16'hFFFF, B=1 -> first gives no trade. Second gives trade_dir=1, trade_spread=16'hFFFE; with ARB_PROFIT_ACCUM_EN, profit_total=16'hFFFE.
- Test 5: packet_valid on 3 consecutive cycles, all qualifying -> exactly one trade_valid, skip_count=2.
- Test 6: assert rst 3 cycles into cooldown and mid-pipeline -> all outputs 0 immediately (asynchronous). A qualifying packet after release trades with 2-cycle latency.

Source files
------------

// File: rtl/arbitrage_detector.sv
// arbitrage_detector: two-stage quote-pair evaluator with cooldown rate limiting.
// Stage 1 registers direction, absolute spread and a zero-quote flag.
// Stage 2 qualifies the opportunity. A two-state FSM (IDLE/COOLDOWN) issues
// one-cycle trade pulses and counts trades and suppressed opportunities.
// Optional feature macro: ARB_PROFIT_ACCUM_EN adds a 32-bit saturating
// profit_total output accumulating the spread of every issued trade.
module arbitrage_detector #(
    parameter int PRICE_W    = 16,
    parameter int MIN_SPREAD = 4,
    parameter int COOLDOWN   = 50000,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRICE_W-1:0] price_A,
    input  logic [PRICE_W-1:0] price_B,
    input  logic               packet_valid,
    output logic               trade_valid,
    output logic               trade_dir,
    output logic [PRICE_W-1:0] trade_spread,
    output logic               busy,
    output logic [CNT_W-1:0]   trade_count,
    output logic [CNT_W-1:0]   skip_count
`ifdef ARB_PROFIT_ACCUM_EN
    ,
    output logic [31:0]        profit_total
`endif
);

    // Cooldown counter only needs to hold COOLDOWN-1.
    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = (COOLDOWN > 0) ? CD_W'(COOLDOWN - 1) : '0;
    localparam logic [PRICE_W:0] MIN_SPREAD_W = MIN_SPREAD[PRICE_W:0];

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_COOLDOWN = 1'b1
    } state_e;

    // Stage 1 combinational terms
    logic [PRICE_W:0]   diff_s;
    logic               a_lt_b_s;
    logic [PRICE_W-1:0] spread_s;
    logic               zero_s;

    // Stage 1 registers
    logic               s1_valid_q;
    logic               s1_a_lt_b_q;
    logic [PRICE_W-1:0] s1_spread_q;
    logic               s1_zero_q;

    // Stage 2 qualification
    logic               opp_s;

    // FSM and output registers
    state_e             state_q, state_d;
    logic [CD_W-1:0]    cd_cnt_q, cd_cnt_d;
    logic               trade_valid_q, trade_valid_d;
    logic               trade_dir_q, trade_dir_d;
    logic [PRICE_W-1:0] trade_spread_q, trade_spread_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   trade_count_q, trade_count_d;
    logic [CNT_W-1:0]   skip_count_q, skip_count_d;

    // Widened subtract: the borrow bit is the A<B flag, so the magnitude never wraps.
    always_comb begin
        diff_s   = {1'b0, price_A} - {1'b0, price_B};
        a_lt_b_s = diff_s[PRICE_W];
        if (a_lt_b_s) begin
            spread_s = price_B - price_A;
        end else begin
            spread_s = diff_s[PRICE_W-1:0];
        end
        zero_s = (price_A == '0) || (price_B == '0);
    end

    // Stage 1 pipeline register: capture the evaluated pair when a packet arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_lt_b_q <= 1'b0;
            s1_spread_q <= '0;
            s1_zero_q   <= 1'b0;
        end else begin
            s1_valid_q <= packet_valid;
            if (packet_valid) begin
                s1_a_lt_b_q <= a_lt_b_s;
                s1_spread_q <= spread_s;
                s1_zero_q   <= zero_s;
            end
        end
    end

    // Stage 2 opportunity: equal prices are excluded even when the threshold is zero.
    always_comb begin
        opp_s = s1_valid_q && !s1_zero_q &&
                ({1'b0, s1_spread_q} >= MIN_SPREAD_W) &&
                (s1_spread_q != '0);
    end

    // FSM next-state and output decode: trade in IDLE, count skips in COOLDOWN.
    always_comb begin
        state_d        = state_q;
        cd_cnt_d       = cd_cnt_q;
        trade_valid_d  = 1'b0;
        trade_dir_d    = trade_dir_q;
        trade_spread_d = trade_spread_q;
        trade_count_d  = trade_count_q;
        skip_count_d   = skip_count_q;
        case (state_q)
            ST_IDLE: begin
                if (opp_s) begin
                    trade_valid_d  = 1'b1;
                    trade_dir_d    = !s1_a_lt_b_q;
                    trade_spread_d = s1_spread_q;
                    if (trade_count_q != '1) begin
                        trade_count_d = trade_count_q + CNT_W'(1);
                    end else begin
                        trade_count_d = trade_count_q;
                    end
                    if (COOLDOWN > 0) begin
                        cd_cnt_d = CD_LOAD;
                        state_d  = ST_COOLDOWN;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COOLDOWN: begin
                if (opp_s && (skip_count_q != '1)) begin
                    skip_count_d = skip_count_q + CNT_W'(1);
                end else begin
                    skip_count_d = skip_count_q;
                end
                if (cd_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cd_cnt_d = cd_cnt_q - CD_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cd_cnt_d = '0;
            end
        endcase
        busy_d = (state_d == ST_COOLDOWN);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cd_cnt_q       <= '0;
            trade_valid_q  <= 1'b0;
            trade_dir_q    <= 1'b0;
            trade_spread_q <= '0;
            busy_q         <= 1'b0;
            trade_count_q  <= '0;
            skip_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            cd_cnt_q       <= cd_cnt_d;
            trade_valid_q  <= trade_valid_d;
            trade_dir_q    <= trade_dir_d;
            trade_spread_q <= trade_spread_d;
            busy_q         <= busy_d;
            trade_count_q  <= trade_count_d;
            skip_count_q   <= skip_count_d;
        end
    end

    assign trade_valid  = trade_valid_q;
    assign trade_dir    = trade_dir_q;
    assign trade_spread = trade_spread_q;
    assign busy         = busy_q;
    assign trade_count  = trade_count_q;
    assign skip_count   = skip_count_q;

`ifdef ARB_PROFIT_ACCUM_EN
    logic [32:0] profit_sum_s;
    logic [31:0] profit_q, profit_d;

    // Saturating profit accumulator, updated on the same edge as the trade pulse.
    always_comb begin
        profit_sum_s = {1'b0, profit_q} + 33'(s1_spread_q);
        if (trade_valid_d) begin
            if (profit_sum_s[32]) begin
                profit_d = 32'hFFFF_FFFF;
            end else begin
                profit_d = profit_sum_s[31:0];
            end
        end else begin
            profit_d = profit_q;
        end
    end

    // Profit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            profit_q <= 32'd0;
        end else begin
            profit_q <= profit_d;
        end
    end

    assign profit_total = profit_q;
`endif

endmodule

// File: tb/tb_arbitrage_detector.sv
// Directed self-checking bench for arbitrage_detector (MIN_SPREAD=4, COOLDOWN=8),
// plus a second instance with MIN_SPREAD=0, COOLDOWN=0 for the equal-price case.
module tb_arbitrage_detector;

    logic        clk;
    logic        rst;
    logic [15:0] price_A;
    logic [15:0] price_B;
    logic        packet_valid;

    logic        trade_valid, trade_dir, busy;
    logic [15:0] trade_spread, trade_count, skip_count;
    logic        d0_trade_valid, d0_trade_dir, d0_busy;
    logic [15:0] d0_trade_spread, d0_trade_count, d0_skip_count;
`ifdef ARB_PROFIT_ACCUM_EN
    logic [31:0] profit_total;
    logic [31:0] d0_profit_total;
`endif

    int checks;
    int failures;

    arbitrage_detector #(
        .PRICE_W(16), .MIN_SPREAD(4), .COOLDOWN(8), .CNT_W(16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .price_A      (price_A),
        .price_B      (price_B),
        .packet_valid (packet_valid),
        .trade_valid  (trade_valid),
        .trade_dir    (trade_dir),
        .trade_spread (trade_spread),
        .busy         (busy),
        .trade_count  (trade_count),
        .skip_count   (skip_count)
`ifdef ARB_PROFIT_ACCUM_EN
        ,
        .profit_total (profit_total)
`endif
    );

    arbitrage_detector #(
        .PRICE_W(16), .MIN_SPREAD(0), .COOLDOWN(0), .CNT_W(16)
    ) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .price_A      (price_A),
        .price_B      (price_B),
        .packet_valid (packet_valid),
        .trade_valid  (d0_trade_valid),
        .trade_dir    (d0_trade_dir),
        .trade_spread (d0_trade_spread),
        .busy         (d0_busy),
        .trade_count  (d0_trade_count),
        .skip_count   (d0_skip_count)
`ifdef ARB_PROFIT_ACCUM_EN
        ,
        .profit_total (d0_profit_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one quote pair for a single cycle.
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        price_A      = a;
        price_B      = b;
        packet_valid = 1'b1;
        tick();
        packet_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 32) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        price_A      = 16'd0;
        price_B      = 16'd0;
        packet_valid = 1'b0;
        tick();
        tick();
        check("rst_tv",    32'(trade_valid),  32'd0);
        check("rst_dir",   32'(trade_dir),    32'd0);
        check("rst_spr",   32'(trade_spread), 32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_tcnt",  32'(trade_count),  32'd0);
        check("rst_scnt",  32'(skip_count),   32'd0);
`ifdef ARB_PROFIT_ACCUM_EN
        check("rst_profit", profit_total, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Test 1: basic trade, latency and cooldown length
        send(16'd100, 16'd105);
        check("t1_lat1", 32'(trade_valid), 32'd0);
        tick();
        check("t1_tv",   32'(trade_valid),  32'd1);
        check("t1_dir",  32'(trade_dir),    32'd0);
        check("t1_spr",  32'(trade_spread), 32'd5);
        check("t1_tcnt", 32'(trade_count),  32'd1);
        check("t1_busy0", 32'(busy),        32'd1);
`ifdef ARB_PROFIT_ACCUM_EN
        check("t1_profit", profit_total, 32'd5);
`endif
        tick();
        check("t1_pulse_end", 32'(trade_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("t1_busy", 32'(busy), 32'd1);
            tick();
        end
        check("t1_busy_last", 32'(busy), 32'd1);
        tick();
        check("t1_busy_fall", 32'(busy), 32'd0);

        // Test 2: sub-threshold spread, and equal prices on the MIN_SPREAD=0 instance
        send(16'd200, 16'd197);
        tick();
        check("t2_tv",   32'(trade_valid), 32'd0);
        check("t2_tcnt", 32'(trade_count), 32'd1);
        check("t2_scnt", 32'(skip_count),  32'd0);
        check("t2_d0_tcnt", 32'(d0_trade_count), 32'd2);
        send(16'd300, 16'd300);
        tick();
        check("t2_eq_tv",     32'(trade_valid),    32'd0);
        check("t2_d0_eq_tv",  32'(d0_trade_valid), 32'd0);
        check("t2_d0_eq_cnt", 32'(d0_trade_count), 32'd2);

        // Test 3: opportunity during cooldown is skipped; trade resumes afterwards
        send(16'd100, 16'd110);
        tick();
        check("t3_tv",   32'(trade_valid),  32'd1);
        check("t3_spr",  32'(trade_spread), 32'd10);
        check("t3_tcnt", 32'(trade_count),  32'd2);
        tick();
        tick();
        send(16'd50, 16'd60);
        tick();
        check("t3_skip_tv",   32'(trade_valid), 32'd0);
        check("t3_skip_scnt", 32'(skip_count),  32'd1);
        check("t3_skip_tcnt", 32'(trade_count), 32'd2);
        wait_idle();
        send(16'd30, 16'd40);
        tick();
        check("t3_resume_tv",   32'(trade_valid), 32'd1);
        check("t3_resume_tcnt", 32'(trade_count), 32'd3);
        wait_idle();

        // Test 3b: opportunity in the cooldown exit cycle is skipped, next one trades
        send(16'd100, 16'd104);
        tick();
        check("t3b_tv",  32'(trade_valid),  32'd1);
        check("t3b_spr", 32'(trade_spread), 32'd4);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        send(16'd7, 16'd70);
        check("t3b_busy_exit", 32'(busy), 32'd1);
        send(16'd70, 16'd7);
        check("t3b_exit_tv",   32'(trade_valid), 32'd0);
        check("t3b_exit_scnt", 32'(skip_count),  32'd2);
        check("t3b_exit_busy", 32'(busy),        32'd0);
        tick();
        check("t3b_next_tv",   32'(trade_valid),  32'd1);
        check("t3b_next_dir",  32'(trade_dir),    32'd1);
        check("t3b_next_spr",  32'(trade_spread), 32'd63);
        check("t3b_next_tcnt", 32'(trade_count),  32'd5);
`ifdef ARB_PROFIT_ACCUM_EN
        check("t3b_profit", profit_total, 32'd92);
`endif
        wait_idle();

        // Test 4: zero quote never trades; maximum spread without wrap
        send(16'd0, 16'd50);
        tick();
        check("t4_zero_tv",   32'(trade_valid), 32'd0);
        check("t4_zero_tcnt", 32'(trade_count), 32'd5);
        send(16'hFFFF, 16'd1);
        tick();
        check("t4_max_tv",  32'(trade_valid),  32'd1);
        check("t4_max_dir", 32'(trade_dir),    32'd1);
        check("t4_max_spr", 32'(trade_spread), 32'h0000_FFFE);
        check("t4_tcnt",    32'(trade_count),  32'd6);
`ifdef ARB_PROFIT_ACCUM_EN
        check("t4_profit", profit_total, 32'd65626);
`endif
        wait_idle();

        // Test 5: three back-to-back qualifying packets -> one trade, two skips
        price_A      = 16'd10;
        price_B      = 16'd20;
        packet_valid = 1'b1;
        tick();
        check("t5_c1_tv", 32'(trade_valid), 32'd0);
        tick();
        check("t5_c2_tv", 32'(trade_valid), 32'd1);
        tick();
        packet_valid = 1'b0;
        check("t5_c3_tv", 32'(trade_valid), 32'd0);
        tick();
        check("t5_c4_tv",   32'(trade_valid), 32'd0);
        check("t5_tcnt",    32'(trade_count), 32'd7);
        check("t5_scnt",    32'(skip_count),  32'd4);
        wait_idle();

        // Test 6: asynchronous reset mid-cooldown and mid-pipeline
        send(16'd100, 16'd120);
        tick();
        check("t6_tv",   32'(trade_valid), 32'd1);
        check("t6_tcnt", 32'(trade_count), 32'd8);
        tick();
        tick();
        tick();
        price_A      = 16'd40;
        price_B      = 16'd90;
        packet_valid = 1'b1;
        tick();
        packet_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_tv",   32'(trade_valid),  32'd0);
        check("t6_rst_dir",  32'(trade_dir),    32'd0);
        check("t6_rst_spr",  32'(trade_spread), 32'd0);
        check("t6_rst_busy", 32'(busy),         32'd0);
        check("t6_rst_tcnt", 32'(trade_count),  32'd0);
        check("t6_rst_scnt", 32'(skip_count),   32'd0);
`ifdef ARB_PROFIT_ACCUM_EN
        check("t6_rst_profit", profit_total, 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("t6_flush_tv",   32'(trade_valid), 32'd0);
        check("t6_flush_tcnt", 32'(trade_count), 32'd0);
        send(16'd5, 16'd100);
        check("t6_post_lat1", 32'(trade_valid), 32'd0);
        tick();
        check("t6_post_tv",   32'(trade_valid),  32'd1);
        check("t6_post_dir",  32'(trade_dir),    32'd0);
        check("t6_post_spr",  32'(trade_spread), 32'd95);
        check("t6_post_tcnt", 32'(trade_count),  32'd1);
        check("t6_post_busy", 32'(busy),         32'd1);
`ifdef ARB_PROFIT_ACCUM_EN
        check("t6_post_profit", profit_total, 32'd95);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
